// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the 5-stage RV32I core.
// Detects load-use hazards, owns the IF/ID/EX advance decisions (stall,
// flush, bubble), drives registered forwarding selects and the trap
// handshake with a bounded wait for trap_ack.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN adds saturating
// stall/flush event counters (perf_stall_cnt, perf_flush_cnt).
module pipe_hazard_ctrl #(
    parameter int XLEN          = 32,
    parameter int TRAP_HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_illegal,
    input  logic       id_rs1en,
    input  logic       id_rs2en,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic [4:0] ex_rd,
    input  logic [4:0] mem_rd,
    input  logic       ex_rd_wen,
    input  logic       mem_rd_wen,
    input  logic       ex_is_load,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    input  logic       trap_ack,
    output logic       if_stall,
    output logic       id_stall,
    output logic       ex_stall,
    output logic       id_flush,
    output logic       ex_bubble,
    output logic [1:0] fwd_rs1_sel,
    output logic [1:0] fwd_rs2_sel,
    output logic       trap_req,
    output logic [2:0] state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
`endif
);

    localparam int TW = $clog2(TRAP_HOLD_MAX + 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LOAD_USE = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_TRAP     = 3'd3
    } state_e;

    if (XLEN < 1 || TRAP_HOLD_MAX < 1) begin : g_param_guard
        $error("pipe_hazard_ctrl: XLEN and TRAP_HOLD_MAX must be positive");
    end

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic            lu_hz_s;
    logic            if_stall_s, id_stall_s, ex_stall_s;
    logic            id_flush_s, ex_bubble_s, trap_req_s;

    // Forwarding source for one operand; EX wins over MEM, x0 never forwards,
    // a load in EX cannot forward (its data is not ready yet).
    function automatic logic [1:0] fwd_pick(
        input logic       rs_en,
        input logic [4:0] rs_addr,
        input logic [4:0] e_rd,
        input logic       e_wen,
        input logic       e_load,
        input logic [4:0] m_rd,
        input logic       m_wen
    );
        logic [1:0] sel;
        if (rs_en && e_wen && (e_rd != 5'd0) && (e_rd == rs_addr) && !e_load) begin
            sel = 2'b01;
        end else if (rs_en && m_wen && (m_rd != 5'd0) && (m_rd == rs_addr)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load-use hazard: ID reads the register the EX-stage load is writing.
    always_comb begin
        lu_hz_s = id_valid && ex_is_load && ex_rd_wen && (ex_rd != 5'd0) &&
                  ((id_rs1en && (id_rs1_addr == ex_rd)) ||
                   (id_rs2en && (id_rs2_addr == ex_rd)));
    end

    // Next-state and per-cycle pipeline controls for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        timer_d     = {TW{1'b0}};
        if_stall_s  = 1'b0;
        id_stall_s  = 1'b0;
        ex_stall_s  = 1'b0;
        id_flush_s  = 1'b0;
        ex_bubble_s = 1'b0;
        trap_req_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    if_stall_s = 1'b1;
                    id_stall_s = 1'b1;
                    ex_stall_s = 1'b1;
                    state_d    = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    id_flush_s  = 1'b1;
                    ex_bubble_s = 1'b1;
                end else if (id_illegal && id_valid) begin
                    trap_req_s  = 1'b1;
                    id_flush_s  = 1'b1;
                    ex_bubble_s = 1'b1;
                    if_stall_s  = 1'b1;
                    state_d     = ST_TRAP;
                end else if (lu_hz_s) begin
                    if_stall_s  = 1'b1;
                    id_stall_s  = 1'b1;
                    ex_bubble_s = 1'b1;
                    state_d     = ST_LOAD_USE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD_USE: begin
                if (mem_busy) begin
                    if_stall_s = 1'b1;
                    id_stall_s = 1'b1;
                    ex_stall_s = 1'b1;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    if_stall_s = 1'b1;
                    id_stall_s = 1'b1;
                    ex_stall_s = 1'b1;
                end else begin
                    state_d     = ST_RUN;
                    id_flush_s  = ex_branch_taken;
                    ex_bubble_s = ex_branch_taken;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d = ST_RUN;
                end else if (timer_q == TW'(TRAP_HOLD_MAX)) begin
                    state_d = ST_RUN;
                end else begin
                    trap_req_s = 1'b1;
                    if_stall_s = 1'b1;
                    timer_d    = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Next forwarding selects: frozen while EX holds, cleared on bubble/flush.
    always_comb begin
        fwd1_d = fwd1_q;
        fwd2_d = fwd2_q;
        if (ex_stall_s) begin
            fwd1_d = fwd1_q;
            fwd2_d = fwd2_q;
        end else if (ex_bubble_s || id_flush_s) begin
            fwd1_d = 2'b00;
            fwd2_d = 2'b00;
        end else begin
            fwd1_d = fwd_pick(id_rs1en, id_rs1_addr, ex_rd, ex_rd_wen, ex_is_load, mem_rd, mem_rd_wen);
            fwd2_d = fwd_pick(id_rs2en, id_rs2_addr, ex_rd, ex_rd_wen, ex_is_load, mem_rd, mem_rd_wen);
        end
    end

    // State, trap timer and forwarding-select registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            timer_q <= {TW{1'b0}};
            fwd1_q  <= 2'b00;
            fwd2_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
        end
    end

    // Controls are forced low while reset is held so nothing advances or traps.
    assign if_stall    = if_stall_s  & ~rst;
    assign id_stall    = id_stall_s  & ~rst;
    assign ex_stall    = ex_stall_s  & ~rst;
    assign id_flush    = id_flush_s  & ~rst;
    assign ex_bubble   = ex_bubble_s & ~rst;
    assign trap_req    = trap_req_s  & ~rst;
    assign fwd_rs1_sel = fwd1_q;
    assign fwd_rs2_sel = fwd2_q;
    assign state_o     = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [XLEN-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {XLEN{1'b0}};
            flush_cnt_q <= {XLEN{1'b0}};
        end else begin
            if (if_stall_s && (stall_cnt_q != {XLEN{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
            end
            if (id_flush_s && (flush_cnt_q != {XLEN{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// sequencer rules (mode variable, hazard equations, timer count).
module tb_pipe_hazard_ctrl;

    localparam int HOLD = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_illegal, id_rs1en, id_rs2en;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd, mem_rd;
    logic       ex_rd_wen, mem_rd_wen, ex_is_load, ex_branch_taken;
    logic       mem_busy, trap_ack;
    logic       if_stall, id_stall, ex_stall, id_flush, ex_bubble, trap_req;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic [2:0] state_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.XLEN(32), .TRAP_HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_illegal(id_illegal),
        .id_rs1en(id_rs1en), .id_rs2en(id_rs2en),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_rd_wen(ex_rd_wen), .mem_rd_wen(mem_rd_wen),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .trap_ack(trap_ack),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .id_flush(id_flush), .ex_bubble(ex_bubble),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .trap_req(trap_req), .state_o(state_o)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 run, 1 load-use, 2 memory wait, 3 trap.
    int         m_mode, m_wait;
    logic [1:0] m_f1, m_f2;
    int         m_sc, m_fc;
    int         nx_mode, nx_wait;
    logic [1:0] nx_f1, nx_f2;
    logic       e_if, e_id, e_ex, e_fl, e_bb, e_tr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_illegal = 1'b0; id_rs1en = 1'b0; id_rs2en = 1'b0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        ex_rd_wen = 1'b0; mem_rd_wen = 1'b0; ex_is_load = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0; trap_ack = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_f1 = 2'b00; m_f2 = 2'b00; m_sc = 0; m_fc = 0;
    endtask

    function automatic logic [1:0] src_for(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 2'b00;
        if (ex_rd_wen && ex_rd == a && !ex_is_load) return 2'b01;
        if (mem_rd_wen && mem_rd == a) return 2'b10;
        return 2'b00;
    endfunction

    // Apply the sequencer rules to the current inputs and model mode.
    task automatic model_eval();
        bit load_use, all_stall;
        load_use = id_valid && ex_is_load && ex_rd_wen && ex_rd != 5'd0 &&
                   ((id_rs1en && id_rs1_addr == ex_rd) || (id_rs2en && id_rs2_addr == ex_rd));
        all_stall = 1'b0;
        {e_if, e_id, e_ex, e_fl, e_bb, e_tr} = 6'b0;
        nx_mode = m_mode; nx_wait = 0;
        if ((m_mode == 0 || m_mode == 1 || m_mode == 2) && mem_busy) begin
            all_stall = 1'b1; nx_mode = 2;
        end else if (m_mode == 0) begin
            if (ex_branch_taken) begin e_fl = 1; e_bb = 1; end
            else if (id_illegal && id_valid) begin e_tr = 1; e_fl = 1; e_bb = 1; e_if = 1; nx_mode = 3; end
            else if (load_use) begin e_if = 1; e_id = 1; e_bb = 1; nx_mode = 1; end
        end else if (m_mode == 1) begin
            nx_mode = 0;
        end else if (m_mode == 2) begin
            nx_mode = 0; e_fl = ex_branch_taken; e_bb = ex_branch_taken;
        end else begin
            if (trap_ack || m_wait >= HOLD) nx_mode = 0;
            else begin e_tr = 1; e_if = 1; nx_wait = m_wait + 1; end
        end
        if (all_stall) begin e_if = 1; e_id = 1; e_ex = 1; end
        if (e_ex) begin nx_f1 = m_f1; nx_f2 = m_f2; end
        else if (e_bb || e_fl) begin nx_f1 = 2'b00; nx_f2 = 2'b00; end
        else begin nx_f1 = src_for(id_rs1en, id_rs1_addr); nx_f2 = src_for(id_rs2en, id_rs2_addr); end
    endtask

    // Let inputs settle, then compare every output with the model.
    task automatic settle_check();
        #1;
        model_eval();
        check_val("if_stall", if_stall, e_if);
        check_val("id_stall", id_stall, e_id);
        check_val("ex_stall", ex_stall, e_ex);
        check_val("id_flush", id_flush, e_fl);
        check_val("ex_bubble", ex_bubble, e_bb);
        check_val("trap_req", trap_req, e_tr);
        check_val("fwd_rs1_sel", fwd_rs1_sel, m_f1);
        check_val("fwd_rs2_sel", fwd_rs2_sel, m_f2);
        check_val("state", state_o, m_mode);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check_val("perf_stall", perf_stall_cnt, m_sc);
        check_val("perf_flush", perf_flush_cnt, m_fc);
`endif
    endtask

    // Clock the DUT and the model, then return to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (e_if) m_sc++;
        if (e_fl) m_fc++;
        m_mode = nx_mode; m_wait = nx_wait; m_f1 = nx_f1; m_f2 = nx_f2;
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic set_load_use_on_5();
        ex_is_load = 1'b1; ex_rd = 5'd5; ex_rd_wen = 1'b1;
        id_valid = 1'b1; id_rs1en = 1'b1; id_rs1_addr = 5'd5;
    endtask

    int held;

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check_val("rst_outputs", {if_stall, id_stall, ex_stall, id_flush, ex_bubble, trap_req}, 32'h0);
        check_val("rst_state", state_o, 32'd0);
        check_val("rst_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Load-use on x5, then the ID instruction advances with MEM/WB forwarding.
        set_load_use_on_5();
        settle_check();
        check_val("lu_stalls", {if_stall, id_stall, ex_bubble}, 32'h7);
        advance();
        check_val("lu_state", state_o, 32'd1);
        clear_inputs();
        id_valid = 1'b1; id_rs1en = 1'b1; id_rs1_addr = 5'd5; mem_rd = 5'd5; mem_rd_wen = 1'b1;
        settle_check();
        check_val("lu_release", {if_stall, id_stall, ex_stall}, 32'h0);
        advance();
        check_val("lu_fwd_memwb", fwd_rs1_sel, 32'h2);
        check_val("lu_back_run", state_o, 32'd0);

        // EX and MEM both write x7: EX/MEM wins; with rd=x0 nothing forwards.
        clear_inputs();
        id_valid = 1'b1; id_rs2en = 1'b1; id_rs2_addr = 5'd7;
        ex_rd = 5'd7; mem_rd = 5'd7; ex_rd_wen = 1'b1; mem_rd_wen = 1'b1;
        step();
        check_val("fwd_ex_prec", fwd_rs2_sel, 32'h1);
        ex_rd = 5'd0; mem_rd = 5'd0; id_rs2_addr = 5'd0;
        step();
        check_val("fwd_x0", fwd_rs2_sel, 32'h0);

        // Taken branch discards a simultaneous load-use hazard.
        clear_inputs();
        set_load_use_on_5();
        ex_branch_taken = 1'b1;
        settle_check();
        check_val("br_flush_bubble", {id_flush, ex_bubble, if_stall}, 32'h6);
        advance();
        check_val("br_state", state_o, 32'd0);

        // Memory wait for three cycles, release on the cycle busy drops.
        clear_inputs();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            check_val("mw_stalls", {if_stall, id_stall, ex_stall}, 32'h7);
            advance();
            check_val("mw_state", state_o, 32'd2);
        end
        mem_busy = 1'b0;
        settle_check();
        check_val("mw_release", {if_stall, id_stall, ex_stall}, 32'h0);
        advance();
        check_val("mw_exit_state", state_o, 32'd0);

        // Trap acknowledged on the fourth cycle of the hold.
        clear_inputs();
        id_valid = 1'b1; id_illegal = 1'b1;
        settle_check();
        check_val("trap_enter", trap_req, 32'h1);
        advance();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            settle_check();
            check_val("trap_hold", trap_req, 32'h1);
            advance();
        end
        trap_ack = 1'b1;
        settle_check();
        check_val("trap_ack_drop", trap_req, 32'h0);
        advance();
        check_val("trap_ack_state", state_o, 32'd0);

        // Trap never acknowledged: count how long the request stays up in TRAP.
        clear_inputs();
        id_valid = 1'b1; id_illegal = 1'b1;
        step();
        clear_inputs();
        held = 0;
        for (int i = 0; i < 40 && state_o == 3'd3; i++) begin
            settle_check();
            if (trap_req) held++;
            advance();
        end
        check_val("trap_timeout_len", held, HOLD);
        check_val("trap_timeout_state", state_o, 32'd0);

        // Asynchronous reset in the middle of a trap hold, with busy inputs.
        id_valid = 1'b1; id_illegal = 1'b1;
        step();
        clear_inputs();
        step();
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_mid_outputs", {if_stall, id_stall, ex_stall, id_flush, ex_bubble, trap_req}, 32'h0);
        check_val("rst_mid_state", state_o, 32'd0);
        check_val("rst_mid_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 32'h0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with small register indices to provoke matches.
        for (int c = 0; c < 2000; c++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            id_illegal      = ($urandom_range(0, 11) == 0);
            id_rs1en        = $urandom_range(0, 1);
            id_rs2en        = $urandom_range(0, 1);
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            mem_rd          = 5'($urandom_range(0, 3));
            ex_rd_wen       = $urandom_range(0, 1);
            mem_rd_wen      = $urandom_range(0, 1);
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0);
            trap_ack        = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
